// File: rtl/player_motion_ctl.sv
// Player sprite motion controller: once per frame (vsync rising edge) it updates position, facing and jump state.
// Optional macro PLAYER_WRAP_EN: horizontal screen wrap instead of edge clamping.
module player_motion_ctl #(
  parameter int unsigned RECT_WIDTH = 48,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned X_INIT     = 296,
  parameter int unsigned FLOOR_Y    = 400,
  parameter int unsigned H_SPEED    = 2,
  parameter int unsigned JUMP_V0    = 12,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned V_MAX      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       game_en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       mirror,
  output logic       module_en,
  output logic       airborne,
  output logic       frame_tick
);

  localparam int unsigned PW = 10;
  localparam int unsigned AW = 11;
  localparam int unsigned VW = 8;

  typedef enum logic [1:0] {IDLE, GROUND, AIR} state_t;

  state_t               state;
  logic                 vsync_d;
  logic signed [VW-1:0] vy;

  logic                 tick_c;
  logic signed [AW-1:0] x_left_c;
  logic signed [AW-1:0] x_right_c;
  logic signed [AW-1:0] y_nxt_c;
  logic signed [VW-1:0] vy_inc_c;
  logic signed [VW-1:0] vy_grav_c;
  logic [PW-1:0]        x_nxt_c;
  logic                 mirror_nxt_c;

  // Next-frame candidates for horizontal and vertical motion
  always_comb begin
    tick_c       = vsync_in & ~vsync_d;
    x_left_c     = $signed({1'b0, xpos}) - $signed(AW'(H_SPEED));
    x_right_c    = $signed({1'b0, xpos}) + $signed(AW'(H_SPEED));
    y_nxt_c      = $signed({1'b0, ypos}) + $signed({{(AW-VW){vy[VW-1]}}, vy});
    vy_inc_c     = vy + $signed(VW'(GRAVITY));
    vy_grav_c    = vy_inc_c;
    x_nxt_c      = xpos;
    mirror_nxt_c = mirror;

    if (vy_inc_c > $signed(VW'(V_MAX))) begin
      vy_grav_c = $signed(VW'(V_MAX));
    end

    if (btn_left && !btn_right) begin
      mirror_nxt_c = 1'b1;
      if (x_left_c[AW-1]) begin
`ifdef PLAYER_WRAP_EN
        x_nxt_c = PW'(x_left_c + $signed(AW'(SCREEN_W)));
`else
        x_nxt_c = '0;
`endif
      end else begin
        x_nxt_c = PW'(x_left_c);
      end
    end else if (btn_right && !btn_left) begin
      mirror_nxt_c = 1'b0;
`ifdef PLAYER_WRAP_EN
      if (x_right_c >= $signed(AW'(SCREEN_W))) begin
        x_nxt_c = PW'(x_right_c - $signed(AW'(SCREEN_W)));
      end else begin
        x_nxt_c = PW'(x_right_c);
      end
`else
      if (x_right_c > $signed(AW'(SCREEN_W - RECT_WIDTH))) begin
        x_nxt_c = PW'(SCREEN_W - RECT_WIDTH);
      end else begin
        x_nxt_c = PW'(x_right_c);
      end
`endif
    end
  end

  // Frame-rate state machine; game_en low overrides everything, even mid-frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vsync_d    <= 1'b1;
      vy         <= '0;
      xpos       <= PW'(X_INIT);
      ypos       <= PW'(FLOOR_Y);
      mirror     <= 1'b0;
      module_en  <= 1'b0;
      airborne   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_d    <= vsync_in;
      frame_tick <= tick_c;
      if (!game_en) begin
        state     <= IDLE;
        vy        <= '0;
        xpos      <= PW'(X_INIT);
        ypos      <= PW'(FLOOR_Y);
        mirror    <= 1'b0;
        module_en <= 1'b0;
        airborne  <= 1'b0;
      end else if (tick_c) begin
        case (state)
          IDLE: begin
            state     <= GROUND;
            module_en <= 1'b1;
          end
          GROUND: begin
            xpos   <= x_nxt_c;
            mirror <= mirror_nxt_c;
            if (btn_jump) begin
              vy       <= -$signed(VW'(JUMP_V0));
              state    <= AIR;
              airborne <= 1'b1;
            end
          end
          AIR: begin
            xpos   <= x_nxt_c;
            mirror <= mirror_nxt_c;
            if (y_nxt_c >= $signed(AW'(FLOOR_Y))) begin
              ypos     <= PW'(FLOOR_Y);
              vy       <= '0;
              state    <= GROUND;
              airborne <= 1'b0;
            end else if (y_nxt_c[AW-1]) begin
              ypos <= '0;
              vy   <= '0;
            end else begin
              ypos <= PW'(y_nxt_c);
              vy   <= vy_grav_c;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/player_motion_ctl.md
# player_motion_ctl

Frame-rate motion controller for the player sprite. It produces `xpos`, `ypos`, `mirror` and `module_en` for the sprite draw stage, using button inputs and a jump/gravity state machine. Every update happens once per video frame, on the rising edge of the VGA vsync. It sits between the input front end and the sprite draw/ROM-address stage in the player layer of the video pipeline.

## Interface
Parameters:
- `RECT_WIDTH`, 48: sprite width in pixels, used for the right-edge limit.
- `SCREEN_W`, 640: visible width in pixels.
- `X_INIT`, 296: x position on entry to IDLE.
- `FLOOR_Y`, 400: y of the sprite top edge when standing.
- `H_SPEED`, 2: horizontal pixels moved per frame.
- `JUMP_V0`, 12: initial upward speed in pixels per frame.
- `GRAVITY`, 1: vy increment per frame.
- `V_MAX`, 12: maximum downward vy.

Ports:
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous, active-high reset.
- `vsync_in`  in  1: VGA vsync from the timing bus; the frame tick is its rising edge.
- `game_en`  in  1: enables play; low forces IDLE.
- `btn_left`, `btn_right`, `btn_jump`  in  1 each: already synchronous to `clk` and debounced.
- `xpos`  out  10: sprite left edge.
- `ypos`  out  10: sprite top edge.
- `mirror`  out  1: 1 = facing left.
- `module_en`  out  1: sprite draw enable.
- `airborne`  out  1: high in AIR.
- `frame_tick`  out  1: one-cycle pulse when a tick is detected.

## Operation
- Tick detection:
  - `vsync_d` registers `vsync_in`.
  - `tick = vsync_in & ~vsync_d`.
  - Buttons are sampled only on tick cycles.
- Vertical speed `vy`: 8-bit two's complement, negative = up.
  - y arithmetic is done at 11-bit signed width, then clamped into the 10-bit `ypos`.
- States: IDLE, GROUND, AIR.
  - IDLE:
    - `module_en`=0, `xpos`=`X_INIT`, `ypos`=`FLOOR_Y`, `vy`=0, `mirror`=0.
    - On a tick with `game_en`=1, go to GROUND.
  - GROUND:
    - `module_en`=1.
    - On a tick with `btn_jump`=1: `vy`←−`JUMP_V0`, go to AIR. `ypos` is unchanged on this tick.
  - AIR, on each tick:
    - `y_nxt = ypos + vy`.
    - `vy ← min(vy + GRAVITY, V_MAX)`.
    - If `y_nxt ≥ FLOOR_Y`: `ypos`←`FLOOR_Y`, `vy`←0, go to GROUND. This is the landing tick; `btn_jump` is ignored on it.
    - Else if `y_nxt < 0`: `ypos`←0, `vy`←0 (ceiling hit), stay in AIR.
    - Otherwise `ypos`←`y_nxt`.
  - `game_en`=0 in any state: go to IDLE on the next clock, without waiting for a tick.
- Horizontal motion, on each tick in GROUND or AIR:
  - Left only: `xpos`−=`H_SPEED`, `mirror`←1.
  - Right only: `xpos`+=`H_SPEED`, `mirror`←0.
  - Both or neither: `xpos` and `mirror` hold.
  - Edge limits: see Configuration.
- Horizontal and vertical updates on the same tick are independent and take effect together.

## Timing
- Reset values:
  - `xpos`=`X_INIT`, `ypos`=`FLOOR_Y`, `mirror`=0, `module_en`=0, `airborne`=0, `frame_tick`=0.
  - State IDLE, `vy`=0.
  - `vsync_d`=1, so a vsync already high at reset release produces no tick.
- All outputs are registered. They change on the clock edge at which `tick` is true, and are stable for the rest of the frame.
- `frame_tick` is high for exactly the one cycle after that edge, aligned with the updated outputs.
- Reset asserted mid-jump: all state returns to the reset values on the next edge; a jump in progress is discarded.
- `game_en` dropping on a tick cycle: IDLE wins; no motion update is applied.

## Configuration
- Macro `PLAYER_WRAP_EN`.
- Defined: the screen wraps horizontally.
  - Moving left below 0: `xpos`←`xpos`+`SCREEN_W`−`H_SPEED`.
  - Moving right to a result ≥ `SCREEN_W`: `xpos`←result−`SCREEN_W`.
- Undefined: `xpos` clamps to the range 0 … `SCREEN_W`−`RECT_WIDTH` (0 … 592 with defaults).

## Test plan
- Reset, then 3 vsync pulses with `game_en`=0 -> `xpos`=296, `ypos`=400, `module_en`=0, and a `frame_tick` pulse one cycle after each vsync rise.
- `game_en`=1, `btn_jump` held on one tick then released -> `airborne`=1. Over the next ticks `ypos` goes 388, 377, 367 …, reaches its apex, and lands back at exactly 400 with `airborne`=0, 25 AIR ticks after the jump tick.
- GROUND at `xpos`=4, `btn_left` held for 4 ticks -> `xpos` 2, 0, 0, 0 and `mirror`=1 (wrap off). With `PLAYER_WRAP_EN`: 2, 0, 638, 636.
- `btn_left` and `btn_right` both held for 2 ticks -> `xpos` and `mirror` unchanged.
- `rst` pulsed mid-jump at `ypos`=350 -> next cycle `ypos`=400, state IDLE, `vy`=0, `module_en`=0.
- `vsync_in` high at reset release -> no `frame_tick` until vsync falls and rises again.
